// File: rtl/vx_om_tile_xbar.sv
// Tile-routed output-merger request crossbar: per-input FIFOs, per-output round-robin, registered outputs.
// Optional perf counters are built when VX_OM_TILE_XBAR_PERF_EN is defined; otherwise the perf ports are tied to 0.
module vx_om_tile_xbar #(
    parameter int NUM_INPUTS   = 4,
    parameter int NUM_OUTPUTS  = 2,
    parameter int DATAW        = 64,
    parameter int DIM_BITS     = 11,
    parameter int TILE_LOGSIZE = 4,
    parameter int IN_DEPTH     = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_INPUTS-1:0]                    req_valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0]              req_data_in,
    input  logic [NUM_INPUTS*DIM_BITS-1:0]           req_pos_x_in,
    input  logic [NUM_INPUTS*DIM_BITS-1:0]           req_pos_y_in,
    output logic [NUM_INPUTS-1:0]                    req_ready_in,
    output logic [NUM_OUTPUTS-1:0]                   req_valid_out,
    output logic [NUM_OUTPUTS*DATAW-1:0]             req_data_out,
    output logic [NUM_OUTPUTS*((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1)-1:0] req_sel_out,
    input  logic [NUM_OUTPUTS-1:0]                   req_ready_out,
    output logic [NUM_OUTPUTS*32-1:0]                perf_stall_out,
    output logic [31:0]                              perf_conflict_out
);

    localparam int SEL_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int DEST_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int AW     = $clog2(IN_DEPTH);
    localparam int CNT_W  = AW + 1;

    typedef struct packed {
        logic [DATAW-1:0]  data;
        logic [DEST_W-1:0] dest;
    } entry_t;

    // Input FIFO state
    entry_t            fifo_mem   [NUM_INPUTS][IN_DEPTH];
    logic [AW-1:0]     wr_ptr_q   [NUM_INPUTS];
    logic [AW-1:0]     wr_ptr_d   [NUM_INPUTS];
    logic [AW-1:0]     rd_ptr_q   [NUM_INPUTS];
    logic [AW-1:0]     rd_ptr_d   [NUM_INPUTS];
    logic [CNT_W-1:0]  count_q    [NUM_INPUTS];
    logic [CNT_W-1:0]  count_d    [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] full, empty, push, pop;
    entry_t            push_entry [NUM_INPUTS];
    entry_t            head       [NUM_INPUTS];

    // Arbitration and output state
    logic [NUM_INPUTS-1:0]  cand      [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] has_grant, load;
    logic [SEL_W-1:0]       grant_idx [NUM_OUTPUTS];
    logic [SEL_W-1:0]       ptr_q     [NUM_OUTPUTS];
    logic [SEL_W-1:0]       ptr_d     [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] valid_q, valid_d;
    logic [DATAW-1:0]       data_q    [NUM_OUTPUTS];
    logic [DATAW-1:0]       data_d    [NUM_OUTPUTS];
    logic [SEL_W-1:0]       sel_q     [NUM_OUTPUTS];
    logic [SEL_W-1:0]       sel_d     [NUM_OUTPUTS];

    // Ready depends only on occupancy, never on a same-cycle pop, so it is glitch-free for the source.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            full[i]            = (count_q[i] == CNT_W'(IN_DEPTH));
            empty[i]           = (count_q[i] == '0);
            req_ready_in[i]    = !full[i];
            push[i]            = req_valid_in[i] && !full[i];
            push_entry[i].data = req_data_in[i*DATAW +: DATAW];
            push_entry[i].dest = DEST_W'(((req_pos_x_in[i*DIM_BITS +: DIM_BITS] >> TILE_LOGSIZE)
                                        ^ (req_pos_y_in[i*DIM_BITS +: DIM_BITS] >> TILE_LOGSIZE))
                                        & DIM_BITS'(NUM_OUTPUTS - 1));
            head[i]            = fifo_mem[i][rd_ptr_q[i]];
            wr_ptr_d[i]        = wr_ptr_q[i] + AW'(push[i]);
            rd_ptr_d[i]        = rd_ptr_q[i] + AW'(pop[i]);
            count_d[i]         = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cand[o][i] = !empty[i] && (head[i].dest == DEST_W'(o));
            end
        end
    end

    // Round-robin search from ptr; a head is only visible to its own dest, so pops never collide.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
        idx = 0;
        pop = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            has_grant[o] = 1'b0;
            grant_idx[o] = '0;
            for (int n = 0; n < NUM_INPUTS; n++) begin
                idx = (int'(ptr_q[o]) + n) % NUM_INPUTS;
                if (cand[o][idx] && !has_grant[o]) begin
                    has_grant[o] = 1'b1;
                    grant_idx[o] = SEL_W'(idx);
                end
            end
            load[o] = has_grant[o] && (!valid_q[o] || req_ready_out[o]);
            if (load[o]) begin
                pop[grant_idx[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            ptr_d[o]   = ptr_q[o];
            valid_d[o] = valid_q[o];
            data_d[o]  = data_q[o];
            sel_d[o]   = sel_q[o];
            if (load[o]) begin
                ptr_d[o]   = (grant_idx[o] == SEL_W'(NUM_INPUTS - 1)) ? '0 : grant_idx[o] + SEL_W'(1);
                valid_d[o] = 1'b1;
                data_d[o]  = head[grant_idx[o]].data;
                sel_d[o]   = grant_idx[o];
            end else if (req_ready_out[o]) begin
                valid_d[o] = 1'b0;
            end
            // Masked during reset so nothing appears to fire in the reset cycle itself.
            req_valid_out[o]                   = valid_q[o] && !reset;
            req_data_out[o*DATAW +: DATAW]     = data_q[o];
            req_sel_out[o*SEL_W +: SEL_W]      = sel_q[o];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                ptr_q[o]  <= '0;
                data_q[o] <= '0;
                sel_q[o]  <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                ptr_q[o]  <= ptr_d[o];
                data_q[o] <= data_d[o];
                sel_q[o]  <= sel_d[o];
            end
            valid_q <= valid_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the occupancy counters decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr_q[i]] <= push_entry[i];
            end
        end
    end

`ifdef VX_OM_TILE_XBAR_PERF_EN
    logic [31:0] stall_q [NUM_OUTPUTS];
    logic [31:0] stall_d [NUM_OUTPUTS];
    logic [31:0] conflict_q, conflict_d;
    logic        any_conflict;

    always_comb begin
        any_conflict = 1'b0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            stall_d[o] = stall_q[o] + 32'(valid_q[o] && !req_ready_out[o]);
            if ($countones(cand[o]) >= 2) begin
                any_conflict = 1'b1;
            end
            perf_stall_out[o*32 +: 32] = stall_q[o];
        end
        conflict_d        = conflict_q + 32'(any_conflict);
        perf_conflict_out = conflict_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                stall_q[o] <= '0;
            end
            conflict_q <= '0;
        end else begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                stall_q[o] <= stall_d[o];
            end
            conflict_q <= conflict_d;
        end
    end
`else
    assign perf_stall_out    = '0;
    assign perf_conflict_out = '0;
`endif

endmodule

// File: tb/tb_vx_om_tile_xbar.sv
// Testbench for vx_om_tile_xbar: directed scenarios plus random traffic, checked by a per-(input,output)
// scoreboard fed at push time and drained by an independent output monitor.
module tb_vx_om_tile_xbar;

    localparam int NI = 4;
    localparam int NO = 2;
    localparam int DW = 64;
    localparam int DB = 11;
    localparam int TL = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NI-1:0]     req_valid_in;
    logic [NI*DW-1:0]  req_data_in;
    logic [NI*DB-1:0]  req_pos_x_in;
    logic [NI*DB-1:0]  req_pos_y_in;
    logic [NI-1:0]     req_ready_in;
    logic [NO-1:0]     req_valid_out;
    logic [NO*DW-1:0]  req_data_out;
    logic [NO*SW-1:0]  req_sel_out;
    logic [NO-1:0]     req_ready_out;
    logic [NO*32-1:0]  perf_stall_out;
    logic [31:0]       perf_conflict_out;

    logic [DW-1:0] d_in [NI];
    logic [DB-1:0] x_in [NI];
    logic [DB-1:0] y_in [NI];

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            req_data_in[i*DW +: DW]  = d_in[i];
            req_pos_x_in[i*DB +: DB] = x_in[i];
            req_pos_y_in[i*DB +: DB] = y_in[i];
        end
    end

    vx_om_tile_xbar #(
        .NUM_INPUTS   (NI),
        .NUM_OUTPUTS  (NO),
        .DATAW        (DW),
        .DIM_BITS     (DB),
        .TILE_LOGSIZE (TL),
        .IN_DEPTH     (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid_in      (req_valid_in),
        .req_data_in       (req_data_in),
        .req_pos_x_in      (req_pos_x_in),
        .req_pos_y_in      (req_pos_y_in),
        .req_ready_in      (req_ready_in),
        .req_valid_out     (req_valid_out),
        .req_data_out      (req_data_out),
        .req_sel_out       (req_sel_out),
        .req_ready_out     (req_ready_out),
        .perf_stall_out    (perf_stall_out),
        .perf_conflict_out (perf_conflict_out)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected payloads per (source input, destination output), in push order.
    logic [DW-1:0] exp_q [NI][NO][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Tile owner: tile coordinates are pixel / tile edge; owner is their xor modulo the unit count.
    function automatic int model_dest(input int x, input int y);
        int tile;
        tile = 1 << TL;
        return ((x / tile) ^ (y / tile)) % NO;
    endfunction

    function automatic int remaining();
        int n;
        n = 0;
        for (int i = 0; i < NI; i++)
            for (int o = 0; o < NO; o++)
                n += exp_q[i][o].size();
        return n;
    endfunction

    task automatic flush_model();
        for (int i = 0; i < NI; i++)
            for (int o = 0; o < NO; o++)
                exp_q[i][o].delete();
    endtask

    task automatic set_req(input int i, input int x, input int y, input logic [DW-1:0] d);
        req_valid_in[i] = 1'b1;
        x_in[i]         = DB'(x);
        y_in[i]         = DB'(y);
        d_in[i]         = d;
    endtask

    // Called at a falling edge after inputs are driven; records accepted pushes, returns at the next falling edge.
    task automatic tick(output logic [NI-1:0] acc);
        #1;
        acc = reset ? '0 : (req_valid_in & req_ready_in);
        for (int i = 0; i < NI; i++)
            if (acc[i]) exp_q[i][model_dest(int'(x_in[i]), int'(y_in[i]))].push_back(d_in[i]);
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        logic [NI-1:0] acc;
        req_valid_in  = '0;
        req_ready_out = '1;
        for (int c = 0; c < n; c++) tick(acc);
    endtask

    // Monitor: every accepted output transfer must match the oldest expected payload for its source/destination.
    initial begin
        int            s;
        logic [DW-1:0] got;
        forever begin
            @(negedge clk);
            #5;
            if (!reset) begin
                for (int o = 0; o < NO; o++) begin
                    if (req_valid_out[o] && req_ready_out[o]) begin
                        s   = int'(req_sel_out[o*SW +: SW]);
                        got = req_data_out[o*DW +: DW];
                        if (exp_q[s][o].size() == 0) begin
                            n_checks++;
                            $display("FAIL out%0d_unexpected: got sel=%0d data=%0h, required no transfer", o, s, got);
                        end else begin
                            check($sformatf("out%0d_from_in%0d", o, s), got, exp_q[s][o].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [NI-1:0] acc;
        int            sent, both, nacc, leak, found_sel;
        logic [31:0]   stall_base, conflict_base;

        reset         = 1'b1;
        req_valid_in  = '0;
        req_ready_out = '1;
        for (int i = 0; i < NI; i++) begin
            d_in[i] = '0;
            x_in[i] = '0;
            y_in[i] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #3;
        check("rst_valid_out", req_valid_out, '0);
        check("rst_data_out",  req_data_out[63:0], '0);
        check("rst_sel_out",   req_sel_out, '0);
        check("rst_ready_in",  req_ready_in, 4'hF);

        // Single request: tile (2,1) -> dest 1, visible two cycles after presentation.
        @(negedge clk);
        set_req(1, 'h25, 'h13, 'hA5);
        tick(acc);
        req_valid_in = '0;
        check("single_accept", acc, 4'b0010);
        #3;
        check("single_early_idle", req_valid_out, 2'b00);
        @(negedge clk);
        #3;
        check("single_valid", req_valid_out, 2'b10);
        check("single_data",  req_data_out[DW +: DW], 'hA5);
        check("single_sel",   req_sel_out[SW +: SW], 1);
        settle(3);

        // Contention: four heads for out0 drain in round-robin order 0,1,2,3.
        conflict_base = perf_conflict_out;
        for (int i = 0; i < NI; i++) set_req(i, i, i, 64'hC0 + 64'(i));
        tick(acc);
        req_valid_in = '0;
        check("cont_accept", acc, 4'hF);
        for (int k = 0; k < NI; k++) begin
            @(negedge clk);
            #3;
            check($sformatf("cont_order_%0d", k), {req_valid_out[0], req_sel_out[SW-1:0]}, {1'b1, SW'(k)});
        end
        @(negedge clk);
        #3;
        check("cont_done", req_valid_out[0], 1'b0);
`ifdef VX_OM_TILE_XBAR_PERF_EN
        check("cont_perf_conflict", 32'(perf_conflict_out - conflict_base), 3);
`endif

        // Pointer wrapped to 0: inputs 3 and 0 compete, 0 goes first.
        @(negedge clk);
        set_req(0, 1, 2, 'hD0);
        set_req(3, 3, 4, 'hD3);
        tick(acc);
        req_valid_in = '0;
        @(negedge clk);
        #3;
        check("wrap_first", req_sel_out[SW-1:0], 0);
        @(negedge clk);
        #3;
        check("wrap_second", req_sel_out[SW-1:0], 3);
        settle(3);

        // Backpressure: out0 held, one in the output register plus four buffered, then ready drops.
        stall_base    = perf_stall_out[31:0];
        req_ready_out = 2'b10;
        sent          = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 9) req_ready_out[0] = 1'b1;
            if (sent < 6) set_req(0, 0, 0, 64'hB00 + 64'(sent));
            else req_valid_in[0] = 1'b0;
            tick(acc);
            if (acc[0]) sent++;
            if (c == 6) begin
                #3;
                check("bp_ready_low", req_ready_in[0], 1'b0);
                check("bp_accepted_5", sent, 5);
                check("bp_out_held", {req_valid_out[0], req_data_out[DW-1:0]}, {1'b1, 64'hB00});
            end
        end
        check("bp_sixth_accepted", sent, 6);
`ifdef VX_OM_TILE_XBAR_PERF_EN
        check("bp_perf_stall", 32'(perf_stall_out[31:0] - stall_base), 7);
`endif
        settle(8);

        // Parallel outputs: both sustain one request per cycle.
        both = 0;
        nacc = 0;
        for (int c = 0; c < 20; c++) begin
            set_req(0, 0, 0, 64'hD000 + 64'(c));
            set_req(1, 16, 0, 64'hE000 + 64'(c));
            tick(acc);
            if (acc[1:0] == 2'b11) nacc++;
            if (c >= 2) begin
                #3;
                if (req_valid_out == 2'b11) both++;
            end
        end
        check("par_accepts", nacc, 20);
        check("par_both_valid", both, 18);
        settle(4);

        // Head-of-line: input 2 head targets stalled out1, so its out0 entry must wait.
        req_ready_out = 2'b01;
        set_req(3, 16, 0, 'hF3);
        tick(acc);
        req_valid_in = '0;
        set_req(2, 16, 0, 'hA2);
        tick(acc);
        set_req(2, 0, 0, 'hB2);
        tick(acc);
        req_valid_in = '0;
        leak = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #3;
            if (req_valid_out[0]) leak++;
        end
        check("hol_no_leak", leak, 0);
        check("hol_out1_held", {req_valid_out[1], req_sel_out[SW +: SW]}, {1'b1, 2'd3});
        @(negedge clk);
        req_ready_out = 2'b11;
        found_sel = -1;
        for (int c = 0; c < 8 && found_sel < 0; c++) begin
            @(negedge clk);
            #3;
            if (req_valid_out[0]) found_sel = int'(req_sel_out[SW-1:0]);
        end
        check("hol_release_sel", found_sel, 2);
        settle(4);

        // Reset mid-stream with requests buffered and in the output registers.
        req_ready_out = 2'b00;
        set_req(0, 0, 0, 'h70);
        set_req(1, 16, 0, 'h71);
        set_req(2, 0, 0, 'h72);
        tick(acc);
        req_valid_in = '0;
        tick(acc);
        reset = 1'b1;
        flush_model();
        tick(acc);
        reset = 1'b0;
        #3;
        check("mrst_valid_out", req_valid_out, 2'b00);
        check("mrst_ready_in", req_ready_in, 4'hF);
        req_ready_out = 2'b11;
        leak = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #3;
            if (req_valid_out != 0) leak++;
        end
        check("mrst_no_stale", leak, 0);

        // Random traffic with random backpressure; the monitor checks every transfer.
        @(negedge clk);
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(i, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), {$urandom, $urandom});
                else
                    req_valid_in[i] = 1'b0;
            end
            for (int o = 0; o < NO; o++) req_ready_out[o] = ($urandom_range(0, 3) != 0);
            tick(acc);
        end
        req_valid_in  = '0;
        req_ready_out = 2'b11;
        for (int c = 0; c < 100 && remaining() != 0; c++) @(negedge clk);
        #6;
        check("drain_empty", remaining(), 0);

`ifndef VX_OM_TILE_XBAR_PERF_EN
        check("perf_stall_zero", perf_stall_out, '0);
        check("perf_conflict_zero", perf_conflict_out, '0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
